// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter granting NUM_CH cache-line requesters one shared memory port via IDLE/BUSY/RESP FSM.
// Optional BUSY watchdog with sticky err_timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter_rr #(
  parameter int NUM_CH         = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int LINE_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               petition,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]    address,
  input  logic [NUM_CH-1:0]               we,
  input  logic [NUM_CH*LINE_WIDTH-1:0]    data_write,
  output logic [NUM_CH-1:0]               serviceReady,
  output logic [LINE_WIDTH-1:0]           data_read,
  output logic [$clog2(NUM_CH)-1:0]       grant_id,
  output logic                            petitionMem,
  output logic [ADDR_WIDTH-1:0]           addressMem,
  output logic                            weMem,
  output logic [LINE_WIDTH-1:0]           dataWriteMem,
  input  logic                            serviceReadyMem,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                            err_timeout,
`endif
  input  logic [LINE_WIDTH-1:0]           dataReadMem
);

  localparam int ID_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] pick;
  logic            pick_vld;
  logic            done;
  logic            tmo;
  int              idx;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  // Search starts one past the last winner; a single subtraction wraps any NUM_CH.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!pick_vld && petition[idx[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (pick_vld) state_nxt = BUSY;
      BUSY: begin
        if (serviceReadyMem) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo       = 1'b1;
          state_nxt = RESP;
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant   <= ID_W'(NUM_CH - 1);
      grant_id     <= '0;
      petitionMem  <= 1'b0;
      addressMem   <= '0;
      weMem        <= 1'b0;
      dataWriteMem <= '0;
      data_read    <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        addressMem   <= address[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
        weMem        <= we[pick];
        dataWriteMem <= data_write[int'(pick)*LINE_WIDTH +: LINE_WIDTH];
        grant_id     <= pick;
        last_grant   <= pick;
        petitionMem  <= 1'b1;
      end
      if (done) begin
        petitionMem <= 1'b0;
        if (!weMem) data_read <= dataReadMem;
      end
      if (tmo) petitionMem <= 1'b0;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE && pick_vld) tmo_cnt <= '0;
      else if (state == BUSY)        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo) err_timeout <= 1'b1;
    end
  end
`endif

  always_comb begin
    serviceReady = '0;
    if (state == RESP) serviceReady[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed test of mem_arbiter_rr with 4 channels; timeout steps run when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter_rr;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    petition;
  logic [63:0]   address;
  logic [3:0]    we;
  logic [1023:0] data_write;
  logic [3:0]    serviceReady;
  logic [255:0]  data_read;
  logic [1:0]    grant_id;
  logic          petitionMem;
  logic [15:0]   addressMem;
  logic          weMem;
  logic [255:0]  dataWriteMem;
  logic          serviceReadyMem;
  logic [255:0]  dataReadMem;
`ifdef MEM_ARB_TIMEOUT_EN
  logic          err_timeout;
`endif

  int total = 0;
  int bad   = 0;
  logic [255:0] last_rd;
  logic [255:0] line_a5;
  logic [255:0] line_tmp;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_CH(4), .ADDR_WIDTH(16), .LINE_WIDTH(256), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .petition(petition), .address(address), .we(we),
    .data_write(data_write), .serviceReady(serviceReady), .data_read(data_read),
    .grant_id(grant_id), .petitionMem(petitionMem), .addressMem(addressMem),
    .weMem(weMem), .dataWriteMem(dataWriteMem), .serviceReadyMem(serviceReadyMem),
`ifdef MEM_ARB_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .dataReadMem(dataReadMem)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; petition = '0; address = '0; we = '0; data_write = '0;
    serviceReadyMem = 1'b0; dataReadMem = '0;
    line_a5 = {32{8'hA5}};
    tick(); tick();
    check("rst_pm", 256'(petitionMem), 256'(1'b0));
    check("rst_sr", 256'(serviceReady), 256'(4'b0000));
    check("rst_gid", 256'(grant_id), 256'(2'd0));
    check("rst_addr", 256'(addressMem), 256'(16'h0));
    check("rst_dr", data_read, 256'h0);
    reset = 1'b1;

    // single read on ch2, memory answers two cycles after petitionMem rises
    address[2*16 +: 16] = 16'h0240;
    petition = 4'b0100;
    tick();
    check("t1_pm", 256'(petitionMem), 256'(1'b1));
    check("t1_addr", 256'(addressMem), 256'(16'h0240));
    check("t1_we", 256'(weMem), 256'(1'b0));
    check("t1_gid", 256'(grant_id), 256'(2'd2));
    tick(); tick();
    check("t1_pm_hold", 256'(petitionMem), 256'(1'b1));
    serviceReadyMem = 1'b1; dataReadMem = {8{32'hCAFE0001}};
    tick();
    serviceReadyMem = 1'b0;
    check("t1_sr", 256'(serviceReady), 256'(4'b0100));
    check("t1_pm_drop", 256'(petitionMem), 256'(1'b0));
    check("t1_dr", data_read, {8{32'hCAFE0001}});
    petition = 4'b0000;
    tick();
    check("t1_sr_off", 256'(serviceReady), 256'(4'b0000));

    // serviceReadyMem while idle is ignored
    serviceReadyMem = 1'b1; dataReadMem = {8{32'hDEAD0000}};
    tick();
    serviceReadyMem = 1'b0;
    check("idle_srm_sr", 256'(serviceReady), 256'(4'b0000));
    check("idle_srm_dr", data_read, {8{32'hCAFE0001}});
    tick();
    check("idle_srm_sr2", 256'(serviceReady), 256'(4'b0000));

    // fresh reset, then all four request: order 0,1,2,3
    reset = 1'b0; tick(); reset = 1'b1;
    petition = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_gid", 256'(grant_id), 256'(k));
      check("t2_pm", 256'(petitionMem), 256'(1'b1));
      serviceReadyMem = 1'b1; dataReadMem = 256'(k + 16);
      tick();
      serviceReadyMem = 1'b0;
      check("t2_sr", 256'(serviceReady), 256'(4'b0001 << k));
      petition[k] = 1'b0;
      tick();
      check("t2_idle_pm", 256'(petitionMem), 256'(1'b0));
      check("t2_idle_sr", 256'(serviceReady), 256'(4'b0000));
    end

    // ch0 and ch1 held high alternate
    petition = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_gid", 256'(grant_id), 256'(i % 2));
      serviceReadyMem = 1'b1; dataReadMem = 256'(i + 100);
      tick();
      serviceReadyMem = 1'b0;
      check("t3_sr", 256'(serviceReady), 256'(4'b0001 << (i % 2)));
      check("t3_dr", data_read, 256'(i + 100));
      tick();
    end
    petition = 4'b0000;
    last_rd = 256'(103);

    // ch3 write of A5 line; inputs change under the registered outputs
    address[3*16 +: 16] = 16'h3F00;
    we[3] = 1'b1;
    data_write[3*256 +: 256] = line_a5;
    petition = 4'b1000;
    tick();
    check("t4_gid", 256'(grant_id), 256'(2'd3));
    check("t4_we", 256'(weMem), 256'(1'b1));
    check("t4_dw", dataWriteMem, line_a5);
    line_tmp = {64{4'h3}};
    data_write[3*256 +: 256] = line_tmp;
    address[3*16 +: 16] = 16'h1111;
    we[3] = 1'b0;
    tick();
    check("t4_dw_stable", dataWriteMem, line_a5);
    check("t4_addr_stable", 256'(addressMem), 256'(16'h3F00));
    check("t4_we_stable", 256'(weMem), 256'(1'b1));
    serviceReadyMem = 1'b1; dataReadMem = {8{32'hBADBAD00}};
    tick();
    serviceReadyMem = 1'b0;
    check("t4_sr", 256'(serviceReady), 256'(4'b1000));
    check("t4_dr_kept", data_read, last_rd);
    petition = 4'b0000;
    tick();

    // reset mid-BUSY with ch1 granted
    petition = 4'b0010;
    tick();
    check("t5_gid", 256'(grant_id), 256'(2'd1));
    check("t5_pm", 256'(petitionMem), 256'(1'b1));
    #2 reset = 1'b0;
    #1;
    check("t5_async_pm", 256'(petitionMem), 256'(1'b0));
    check("t5_async_sr", 256'(serviceReady), 256'(4'b0000));
    tick();
    reset = 1'b1;
    petition = 4'b0011;
    tick();
    check("t5_regrant", 256'(grant_id), 256'(2'd0));
    check("t5_pm2", 256'(petitionMem), 256'(1'b1));
    serviceReadyMem = 1'b1;
    tick();
    serviceReadyMem = 1'b0;
    check("t5_sr", 256'(serviceReady), 256'(4'b0001));
    petition = 4'b0000;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never answers: petitionMem high for 8 BUSY cycles
    check("t6_err0", 256'(err_timeout), 256'(1'b0));
    petition = 4'b0001;
    tick();
    check("t6_pm_c1", 256'(petitionMem), 256'(1'b1));
    for (int c = 2; c <= 8; c++) begin
      tick();
      check("t6_pm_busy", 256'(petitionMem), 256'(1'b1));
    end
    last_rd = data_read;
    tick();
    check("t6_pm_drop", 256'(petitionMem), 256'(1'b0));
    check("t6_sr", 256'(serviceReady), 256'(4'b0001));
    check("t6_err", 256'(err_timeout), 256'(1'b1));
    check("t6_dr", data_read, last_rd);
    petition = 4'b0000;
    tick(); tick();
    check("t6_err_sticky", 256'(err_timeout), 256'(1'b1));
    reset = 1'b0; #1;
    check("t6_err_rst", 256'(err_timeout), 256'(1'b0));
    reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
